// File: rtl/bsg_axil_txs_buffered.sv
// AXI-Lite write slave that steers host writes into per-channel transmit FIFOs.
// Optional build macro: BSG_AXIL_TXS_WSTRB_CHECK_EN (reject partial-strobe writes with SLVERR).
module bsg_axil_txs_buffered #(
    parameter int unsigned num_fifos_p   = 4,
    parameter int unsigned data_width_p  = 32,
    parameter int unsigned fifo_els_p    = 8,
    parameter logic [31:0] base_addr_p   = 32'h0000_1000,
    parameter int unsigned slot_width_p  = 8,
    parameter logic [7:0]  tdr_ofs_p     = 8'h10,
    parameter logic [7:0]  isr_ofs_p     = 8'h00,
    parameter int unsigned isr_txc_bit_p = 27
) (
    input  logic                                               clk_i,
    input  logic                                               reset_n_i,
    input  logic [31:0]                                        awaddr_i,
    input  logic                                               awvalid_i,
    output logic                                               awready_o,
    input  logic [data_width_p-1:0]                            wdata_i,
    input  logic [data_width_p/8-1:0]                          wstrb_i,
    input  logic                                               wvalid_i,
    output logic                                               wready_o,
    output logic [1:0]                                         bresp_o,
    output logic                                               bvalid_o,
    input  logic                                               bready_i,
    output logic [num_fifos_p*data_width_p-1:0]                txs_o,
    output logic [num_fifos_p-1:0]                             txs_v_o,
    input  logic [num_fifos_p-1:0]                             txs_ready_i,
    output logic [num_fifos_p*$clog2(fifo_els_p+1)-1:0]        vacancy_o,
    output logic [num_fifos_p-1:0]                             clr_isrs_txc_o
);

    localparam int unsigned ptr_w  = $clog2(fifo_els_p);
    localparam int unsigned cnt_w  = $clog2(fifo_els_p + 1);
    localparam int unsigned idx_w  = (num_fifos_p > 1) ? $clog2(num_fifos_p) : 1;
    localparam int unsigned strb_w = data_width_p / 8;

    localparam logic [31:0] slot_mask = (32'd1 << slot_width_p) - 32'd1;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StDispatch = 2'd1;
    localparam logic [1:0] StResp     = 2'd2;

    logic [1:0]              state_r, state_d;
    logic                    aw_full_r, w_full_r;
    logic [31:0]             addr_r;
    logic [data_width_p-1:0] data_r;
    logic [1:0]              resp_r, resp_d;
    logic                    aw_hs, w_hs, dispatch;
    logic                    strb_ok;

    logic [31:0]             rel, slot, ofs;
    logic                    in_range, tdr_hit, isr_hit;
    logic [idx_w-1:0]        idx;
    logic [1:0]              dec_resp;
    logic                    enq_any, pulse_any;
    logic [num_fifos_p-1:0]  fifo_full;

    assign awready_o = !aw_full_r && (state_r == StIdle);
    assign wready_o  = !w_full_r && (state_r == StIdle);
    assign aw_hs     = awvalid_i && awready_o;
    assign w_hs      = wvalid_i && wready_o;
    assign dispatch  = (state_r == StDispatch);
    assign bvalid_o  = (state_r == StResp);
    assign bresp_o   = (state_r == StResp) ? resp_r : 2'b00;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            aw_full_r <= 1'b0;
            w_full_r  <= 1'b0;
            addr_r    <= '0;
            data_r    <= '0;
            state_r   <= StIdle;
            resp_r    <= RespOkay;
        end else begin
            if (aw_hs) begin
                aw_full_r <= 1'b1;
                addr_r    <= awaddr_i;
            end else if (dispatch) begin
                aw_full_r <= 1'b0;
            end
            if (w_hs) begin
                w_full_r <= 1'b1;
                data_r   <= wdata_i;
            end else if (dispatch) begin
                w_full_r <= 1'b0;
            end
            state_r <= state_d;
            resp_r  <= resp_d;
        end
    end

`ifdef BSG_AXIL_TXS_WSTRB_CHECK_EN
    logic [strb_w-1:0] strb_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            strb_r <= '0;
        end else if (w_hs) begin
            strb_r <= wstrb_i;
        end
    end

    assign strb_ok = &strb_r;
`else
    logic unused_strb;

    assign unused_strb = ^wstrb_i;
    assign strb_ok     = 1'b1;
`endif

    // Dispatch fires the cycle after the later of the two handshakes, so look at next-state flags.
    always_comb begin
        state_d = state_r;
        case (state_r)
            StIdle: begin
                if ((aw_full_r || aw_hs) && (w_full_r || w_hs)) state_d = StDispatch;
            end
            StDispatch: state_d = StResp;
            StResp: begin
                if (bready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rel      = addr_r - base_addr_p;
        slot     = rel >> slot_width_p;
        ofs      = addr_r & slot_mask;
        in_range = (addr_r >= base_addr_p) && (slot < num_fifos_p);
        idx      = slot[idx_w-1:0];
        tdr_hit  = in_range && (ofs == 32'(tdr_ofs_p));
        isr_hit  = in_range && (ofs == 32'(isr_ofs_p));

        if (!tdr_hit && !isr_hit) begin
            dec_resp = RespDecErr;
        end else if (!strb_ok) begin
            dec_resp = RespSlvErr;
        end else if (tdr_hit && fifo_full[idx]) begin
            // Drop rather than stall so a full channel can never wedge the interconnect.
            dec_resp = RespSlvErr;
        end else begin
            dec_resp = RespOkay;
        end

        enq_any   = dispatch && tdr_hit && strb_ok && !fifo_full[idx];
        pulse_any = dispatch && isr_hit && strb_ok && data_r[isr_txc_bit_p];
        resp_d    = dispatch ? dec_resp : resp_r;
    end

    for (genvar g = 0; g < num_fifos_p; g++) begin : gen_fifo
        logic [data_width_p-1:0] mem [fifo_els_p];
        logic [ptr_w-1:0]        rd_ptr, wr_ptr;
        logic [cnt_w-1:0]        count, count_next, vacancy;
        logic                    enq, deq;

        assign enq = enq_any && (idx == idx_w'(g));
        assign deq = (count != '0) && txs_ready_i[g];

        always_comb begin
            count_next = count;
            if (enq && !deq) begin
                count_next = count + cnt_w'(1);
            end else if (!enq && deq) begin
                count_next = count - cnt_w'(1);
            end
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                vacancy <= cnt_w'(fifo_els_p);
            end else begin
                if (enq) wr_ptr <= wr_ptr + ptr_w'(1);
                if (deq) rd_ptr <= rd_ptr + ptr_w'(1);
                count   <= count_next;
                vacancy <= cnt_w'(fifo_els_p) - count_next;
            end
        end

        // Storage needs no reset: the count alone defines which entries are live.
        always_ff @(posedge clk_i) begin
            if (enq) mem[wr_ptr] <= data_r;
        end

        assign fifo_full[g]                               = (count == cnt_w'(fifo_els_p));
        assign txs_v_o[g]                                 = (count != '0);
        assign txs_o[g*data_width_p +: data_width_p]      = mem[rd_ptr];
        assign vacancy_o[g*cnt_w +: cnt_w]                = vacancy;
        assign clr_isrs_txc_o[g]                          = pulse_any && (idx == idx_w'(g));
    end

endmodule
